// File: rtl/sevenseg_scanner.sv
// sevenseg_scanner
//   Time-multiplexed driver for a 4-digit common-anode seven-segment display.
//   Each digit gets REFRESH_DIV clock cycles; the first GUARD cycles of every
//   slot are blanked to suppress ghosting. The 16-bit value is captured once
//   per frame (end of digit 3) so a frame never shows a torn value.
//
// Ports
//   clk         rising-edge clock
//   i_reset_n   asynchronous active-low reset
//   i_count     [0:31] value to show; only i_count[16:31] (low 16 bits) used
//   i_hold      freezes the snapshot while high
//   i_blank_lz  enables leading-zero blanking
//   i_dp_mask   [0:3] bit k lights the decimal point of digit k
//   seg         [0:6] active-low segments a..g (seg[0]=a)
//   an          [0:3] active-low anodes, an[0] = rightmost digit
//   dp          active-low decimal point
//   o_frame     one-cycle pulse after each snapshot load
module sevenseg_scanner #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 4
) (
  input  logic        clk,
  input  logic        i_reset_n,
  input  logic [0:31] i_count,
  input  logic        i_hold,
  input  logic        i_blank_lz,
  input  logic [0:3]  i_dp_mask,
  output logic [0:6]  seg,
  output logic [0:3]  an,
  output logic        dp,
  output logic        o_frame
);

  localparam int unsigned SLOT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] GUARD_END = SLOT_W'(GUARD);

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        digit_q, digit_d;
  logic [15:0]       snap_q, snap_d;
  logic              frame_q, frame_d;
  logic [0:6]        seg_q, seg_d;
  logic [0:3]        an_q, an_d;
  logic              dp_q, dp_d;

  logic              slot_wrap;
  logic              load;
  logic [3:0]        nibble;
  logic              upper_zero;
  logic              active;
  logic              lz_blank;
  logic              unused_count_hi;

  function automatic logic [0:6] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'b0000001;
      4'h1: font = 7'b1001111;
      4'h2: font = 7'b0010010;
      4'h3: font = 7'b0000110;
      4'h4: font = 7'b1001100;
      4'h5: font = 7'b0100100;
      4'h6: font = 7'b0100000;
      4'h7: font = 7'b0001111;
      4'h8: font = 7'b0000000;
      4'h9: font = 7'b0000100;
      4'hA: font = 7'b0001000;
      4'hB: font = 7'b1100000;
      4'hC: font = 7'b0110001;
      4'hD: font = 7'b1000010;
      4'hE: font = 7'b0110000;
      default: font = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    unused_count_hi = ^i_count[0:15];
  end

  // Slot / digit sequencing and snapshot capture
  always_comb begin
    slot_wrap = (slot_q == SLOT_LAST);
    load      = slot_wrap && (digit_q == 2'd3) && !i_hold;
    slot_d    = slot_wrap ? '0 : slot_q + 1'b1;
    digit_d   = slot_wrap ? digit_q + 2'd1 : digit_q;
    // i_count is declared [0:31], so [16:31] keeps its numeric order here
    snap_d    = load ? i_count[16:31] : snap_q;
    frame_d   = load;
  end

  // Display decode for the current state; registered below, so the pins
  // lag the slot counter by one cycle.
  always_comb begin
    nibble     = snap_q[3:0];
    upper_zero = 1'b0;
    case (digit_q)
      2'd0: begin nibble = snap_q[3:0];   upper_zero = 1'b0;                end
      2'd1: begin nibble = snap_q[7:4];   upper_zero = (snap_q[15:4] == '0);  end
      2'd2: begin nibble = snap_q[11:8];  upper_zero = (snap_q[15:8] == '0);  end
      default: begin nibble = snap_q[15:12]; upper_zero = (snap_q[15:12] == '0); end
    endcase
    active   = (slot_q >= GUARD_END);
    lz_blank = i_blank_lz && upper_zero;

    an_d  = '1;
    seg_d = '1;
    dp_d  = 1'b1;
    if (active) begin
      dp_d = ~i_dp_mask[digit_q];
      if (!lz_blank) begin
        an_d[digit_q] = 1'b0;
        seg_d         = font(nibble);
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      slot_q  <= '0;
      digit_q <= '0;
      snap_q  <= '0;
      frame_q <= 1'b0;
      seg_q   <= '1;
      an_q    <= '1;
      dp_q    <= 1'b1;
    end else begin
      slot_q  <= slot_d;
      digit_q <= digit_d;
      snap_q  <= snap_d;
      frame_q <= frame_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  always_comb begin
    seg     = seg_q;
    an      = an_q;
    dp      = dp_q;
    o_frame = frame_q;
  end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Directed testbench for sevenseg_scanner with REFRESH_DIV=8, GUARD=2.
// One frame = 4 digits x 8 cycles = 32 cycles; each tick samples outputs
// 1 time unit after the rising edge.
module tb_sevenseg_scanner;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic [0:31] i_count;
  logic        i_hold;
  logic        i_blank_lz;
  logic [0:3]  i_dp_mask;
  logic [0:6]  seg;
  logic [0:3]  an;
  logic        dp;
  logic        o_frame;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sevenseg_scanner #(
    .REFRESH_DIV(8),
    .GUARD      (2)
  ) dut (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .i_count   (i_count),
    .i_hold    (i_hold),
    .i_blank_lz(i_blank_lz),
    .i_dp_mask (i_dp_mask),
    .seg       (seg),
    .an        (an),
    .dp        (dp),
    .o_frame   (o_frame)
  );

  // Hand-written font, seg[0:6] = a..g, 0 = lit
  function automatic logic [0:6] font_of(input logic [3:0] n);
    case (n)
      4'h0: font_of = 7'b0000001;
      4'h1: font_of = 7'b1001111;
      4'h2: font_of = 7'b0010010;
      4'h3: font_of = 7'b0000110;
      4'h4: font_of = 7'b1001100;
      4'h5: font_of = 7'b0100100;
      4'h6: font_of = 7'b0100000;
      4'h7: font_of = 7'b0001111;
      4'h8: font_of = 7'b0000000;
      4'h9: font_of = 7'b0000100;
      4'hA: font_of = 7'b0001000;
      4'hB: font_of = 7'b1100000;
      4'hC: font_of = 7'b0110001;
      4'hD: font_of = 7'b1000010;
      4'hE: font_of = 7'b0110000;
      default: font_of = 7'b0111000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Step through frame positions p0..p1 (0..31) and check every output.
  // val is the snapshot expected on screen; exp_pulse is o_frame at p=31.
  task automatic run(input logic [15:0] val, input logic blz, input logic [0:3] dpm,
                     input logic exp_pulse, input int unsigned p0, input int unsigned p1);
    logic [0:3]  exp_an;
    logic [0:6]  exp_seg;
    logic        exp_dp;
    logic        chk_seg;
    logic [15:0] upper;
    int unsigned d;
    int unsigned s;
    if (p0 == 0) begin
      i_blank_lz = blz;
      i_dp_mask  = dpm;
    end
    for (int unsigned p = p0; p <= p1; p++) begin
      tick();
      d       = p / 8;
      s       = p % 8;
      exp_an  = '1;
      exp_seg = '1;
      exp_dp  = 1'b1;
      chk_seg = 1'b1;
      if (s >= 2) begin
        upper  = val >> (4 * d);
        exp_dp = ~dpm[d];
        if (blz && d > 0 && upper == 16'h0000) begin
          chk_seg = 1'b0;
        end else begin
          exp_an[d] = 1'b0;
          exp_seg   = font_of(upper[3:0]);
        end
      end
      check($sformatf("an p%0d val=%h", p, val), 7'(an), 7'(exp_an));
      if (chk_seg) check($sformatf("seg p%0d val=%h", p, val), seg, exp_seg);
      check($sformatf("dp p%0d val=%h", p, val), 7'(dp), 7'(exp_dp));
      check($sformatf("o_frame p%0d", p), 7'(o_frame), 7'((p == 31) ? exp_pulse : 1'b0));
    end
  endtask

  // At most one anode low at any sampled point
  always @(negedge clk) begin
    checks++;
    assert (($countones(~an) <= 1) === 1'b1) else begin
      errors++;
      $error("FAIL onehot_an: observed an=%b expected at most one low bit", an);
    end
  end

  logic [0:3] dpm2;

  initial begin
    dpm2       = '0;
    dpm2[2]    = 1'b1;
    i_reset_n  = 1'b1;
    i_count    = 32'h0000_1234;
    i_hold     = 1'b0;
    i_blank_lz = 1'b0;
    i_dp_mask  = '0;
    #2 i_reset_n = 1'b0;
    tick();
    tick();
    check("rst an", 7'(an), 7'b0001111);
    check("rst seg", seg, 7'b1111111);
    check("rst dp", 7'(dp), 7'd1);
    check("rst o_frame", 7'(o_frame), 7'd0);
    @(negedge clk);
    i_reset_n = 1'b1;

    // Frame 0 shows reset snapshot 0, loads 1234 at its end
    run(16'h0000, 1'b0, 4'b0000, 1'b1, 0, 31);
    // Frame 1 shows 1234; i_count changes mid-frame without tearing
    run(16'h1234, 1'b0, 4'b0000, 1'b0, 0, 12);
    i_count = 32'h0000_ABCD;
    run(16'h1234, 1'b0, 4'b0000, 1'b1, 13, 31);
    // Frame 2 shows ABCD; hold raised before its end with a new count
    run(16'hABCD, 1'b0, 4'b0000, 1'b0, 0, 19);
    i_hold  = 1'b1;
    i_count = 32'h0000_5678;
    run(16'hABCD, 1'b0, 4'b0000, 1'b0, 20, 31);
    // Frame 3 still ABCD; hold released, so 5678 loads at its end
    run(16'hABCD, 1'b0, 4'b0000, 1'b0, 0, 4);
    i_hold = 1'b0;
    run(16'hABCD, 1'b0, 4'b0000, 1'b1, 5, 31);
    // Frame 4 shows 5678; zero value queued
    run(16'h5678, 1'b0, 4'b0000, 1'b0, 0, 2);
    i_count = 32'h0000_0000;
    run(16'h5678, 1'b0, 4'b0000, 1'b1, 3, 31);
    // Frame 5: leading-zero blanking of an all-zero value
    run(16'h0000, 1'b1, 4'b0000, 1'b0, 0, 2);
    i_count = 32'h0000_0105;
    run(16'h0000, 1'b1, 4'b0000, 1'b1, 3, 31);
    // Frame 6: 0105 with blanking and decimal point on digit 2
    run(16'h0105, 1'b1, dpm2, 1'b1, 0, 31);
    // Frame 7: 0105 without blanking
    run(16'h0105, 1'b0, dpm2, 1'b1, 0, 31);
    // Frame 8: reset mid-slot while digit 2 is lit
    run(16'h0105, 1'b0, 4'b0000, 1'b0, 0, 20);
    check("pre-rst an", 7'(an), 7'b0001101);
    #3 i_reset_n = 1'b0;
    #1;
    check("async rst an", 7'(an), 7'b0001111);
    check("async rst seg", seg, 7'b1111111);
    check("async rst dp", 7'(dp), 7'd1);
    check("async rst o_frame", 7'(o_frame), 7'd0);
    tick();
    tick();
    check("held rst an", 7'(an), 7'b0001111);
    @(negedge clk);
    i_reset_n = 1'b1;
    // Restart from digit 0 showing 0; 0105 loads at frame end
    run(16'h0000, 1'b0, 4'b0000, 1'b1, 0, 31);
    run(16'h0105, 1'b0, 4'b0000, 1'b1, 0, 31);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
